mapping_group_ctrl: RTL and testbench

- Sequencer for one mapping-group shift datapath.
- Per operation it steps the datapath through 4 bit-pair slices. For each slice it issues the buffer write strobe(s) as eFlash data arrives, issues the buffer read, samples the shifted slice output and advances the datapath shift counter.
- Slice outputs accumulate into one result, returned on a valid/ready handshake. Sits between the PIM top-level controller and the output-buffer datapath.

---
 rtl/mapping_group_ctrl.sv | 132 +++++++++++++
 tb/tb_mapping_group_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mapping_group_ctrl.sv
// Mapping-group shift sequencer: steps the datapath through bit-pair
// slices, accumulates slice outputs and returns one handshaked result.
module mapping_group_ctrl #(
  parameter logic [2:0] PIM_PARALLEL = 3'b100,
  parameter logic [2:0] PIM_RBR      = 3'b101,
  parameter int         NUM_STEPS    = 4,
  parameter int         ACC_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [2:0]           pim_mode_i,
  input  logic                 eflash_valid_i,
  output logic                 eflash_req_o,
  output logic                 buf_write_en_1_o,
  output logic                 buf_write_en_2_o,
  output logic                 buf_read_en_o,
  output logic                 shift_counter_en_o,
  input  logic [31:0]          mapped_i,
  output logic                 busy_o,
  output logic [ACC_WIDTH-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic                 mode_err_o
);

  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR1   = 3'd1;
  localparam logic [2:0] WR2   = 3'd2;
  localparam logic [2:0] RD    = 3'd3;
  localparam logic [2:0] ACC   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] FLUSH = 3'd6;

  logic [2:0]           state, state_d;
  logic [2:0]           mode_q;
  logic [SW-1:0]        step_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 mode_ok;
  logic                 last;
  logic                 accept;

  assign mode_ok = (pim_mode_i == PIM_PARALLEL) ||
                   (pim_mode_i == PIM_RBR);
  assign last    = (step_cnt == SW'(NUM_STEPS - 1));
  assign accept  = (state == IDLE) && start_i;

  always_comb begin
    state_d            = state;
    eflash_req_o       = 1'b0;
    buf_write_en_1_o   = 1'b0;
    buf_write_en_2_o   = 1'b0;
    buf_read_en_o      = 1'b0;
    shift_counter_en_o = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && mode_ok) state_d = WR1;
      end
      WR1: begin
        eflash_req_o = 1'b1;
        if (abort_i) begin
          state_d = FLUSH;
        end else if (eflash_valid_i) begin
          buf_write_en_1_o = 1'b1;
          state_d = (mode_q == PIM_RBR) ? WR2 : RD;
        end
      end
      WR2: begin
        eflash_req_o = 1'b1;
        if (abort_i) begin
          state_d = FLUSH;
        end else if (eflash_valid_i) begin
          buf_write_en_2_o = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        if (abort_i) begin
          state_d = FLUSH;
        end else begin
          buf_read_en_o = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        shift_counter_en_o = 1'b1;
        if (last) state_d = abort_i ? IDLE : DONE;
        else      state_d = abort_i ? FLUSH : WR1;
      end
      DONE: begin
        if (abort_i || result_ready_i) state_d = IDLE;
      end
      FLUSH: begin
        // Keep the clearless datapath counter aligned for the next op
        shift_counter_en_o = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      mode_q     <= '0;
      step_cnt   <= '0;
      acc        <= '0;
      mode_err_o <= 1'b0;
    end else begin
      state      <= state_d;
      mode_err_o <= accept && !mode_ok;
      if (accept && mode_ok) begin
        mode_q   <= pim_mode_i;
        acc      <= '0;
        step_cnt <= '0;
      end else begin
        if (state == ACC)
          acc <= acc + ACC_WIDTH'(mapped_i);
        if (shift_counter_en_o)
          step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  assign busy_o         = (state != IDLE);
  assign result_valid_o = (state == DONE);
  assign result_o       = result_valid_o ? acc : '0;

endmodule

// File: tb/tb_mapping_group_ctrl.sv
// Directed bench for mapping_group_ctrl with a small datapath
// counter model and an expected-result queue.
module tb_mapping_group_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic        abort_i;
  logic [2:0]  pim_mode_i;
  logic        eflash_valid_i;
  logic        eflash_req_o;
  logic        buf_write_en_1_o;
  logic        buf_write_en_2_o;
  logic        buf_read_en_o;
  logic        shift_counter_en_o;
  logic [31:0] mapped_i;
  logic        busy_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        result_ready_i;
  logic        mode_err_o;

  mapping_group_ctrl dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .abort_i            (abort_i),
    .pim_mode_i         (pim_mode_i),
    .eflash_valid_i     (eflash_valid_i),
    .eflash_req_o       (eflash_req_o),
    .buf_write_en_1_o   (buf_write_en_1_o),
    .buf_write_en_2_o   (buf_write_en_2_o),
    .buf_read_en_o      (buf_read_en_o),
    .shift_counter_en_o (shift_counter_en_o),
    .mapped_i           (mapped_i),
    .busy_o             (busy_o),
    .result_o           (result_o),
    .result_valid_o     (result_valid_o),
    .result_ready_i     (result_ready_i),
    .mode_err_o         (mode_err_o)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mvals [4];
  logic [1:0]  dp_cnt;
  logic        tgl, ph, ev_c;
  logic        rbr_chk;
  int n_w1 = 0, n_w2 = 0, n_rd = 0, n_sh = 0;
  int n_bad = 0, n_vld = 0, last_w = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign eflash_valid_i = tgl ? ph : ev_c;
  assign mapped_i = mvals[dp_cnt];

  always @(negedge clk_i) ph <= tgl ? ~ph : 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dp_cnt <= 2'd0;
    else if (shift_counter_en_o) dp_cnt <= dp_cnt + 2'd1;
  end

  always @(posedge clk_i) begin
    if (buf_write_en_1_o) n_w1 <= n_w1 + 1;
    if (buf_write_en_2_o) n_w2 <= n_w2 + 1;
    if (buf_read_en_o) n_rd <= n_rd + 1;
    if (shift_counter_en_o) n_sh <= n_sh + 1;
    if (result_valid_o) n_vld <= n_vld + 1;
    if ((buf_write_en_1_o || buf_write_en_2_o) && !eflash_valid_i)
      n_bad <= n_bad + 1;
    if (int'(buf_write_en_1_o) + int'(buf_write_en_2_o) +
        int'(buf_read_en_o) + int'(shift_counter_en_o) > 1)
      n_bad <= n_bad + 1;
    if (!rbr_chk) begin
      last_w <= 2;
    end else begin
      if (buf_write_en_1_o) begin
        if (last_w == 1) n_bad <= n_bad + 1;
        last_w <= 1;
      end
      if (buf_write_en_2_o) begin
        if (last_w != 1) n_bad <= n_bad + 1;
        last_w <= 2;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {eflash_req_o, buf_write_en_1_o, buf_write_en_2_o,
            buf_read_en_o, shift_counter_en_o, busy_o,
            result_valid_o, mode_err_o};
  endfunction

  task automatic start_op(input logic [2:0] m);
    @(negedge clk_i);
    pim_mode_i = m;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int n = 1;
    while (!result_valid_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    lat = n - 1;
  endtask

  task automatic take_result(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, 32'(result_valid_o), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    chk({tag, "_result"}, result_o, e);
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    chk({tag, "_vdrop"}, 32'(result_valid_o), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int lat, w1_0, w2_0, rd_0, sh_0, v0, n;
    logic [31:0] held;
    rst_ni = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    pim_mode_i = 3'b000;
    result_ready_i = 1'b0;
    tgl = 1'b0;
    ev_c = 1'b1;
    rbr_chk = 1'b0;
    for (int i = 0; i < 4; i++) mvals[i] = 32'd0;
    #2;
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_result", result_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    mvals[0] = 32'd5; mvals[1] = 32'd7;
    mvals[2] = 32'd1; mvals[3] = 32'd2;
    w1_0 = n_w1; w2_0 = n_w2; rd_0 = n_rd; sh_0 = n_sh;
    exp_q.push_back(32'd15);
    start_op(3'b100);
    wait_valid(lat);
    chk("par_latency", 32'(lat), 32'd12);
    chk("par_w1", 32'(n_w1 - w1_0), 32'd4);
    chk("par_w2", 32'(n_w2 - w2_0), 32'd0);
    chk("par_rd", 32'(n_rd - rd_0), 32'd4);
    chk("par_sh", 32'(n_sh - sh_0), 32'd4);
    held = result_o;
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 3);
      pim_mode_i = 3'b100;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("bp_valid", 32'(result_valid_o), 32'd1);
      chk("bp_hold", result_o, held);
    end
    take_result("par");

    for (int i = 0; i < 4; i++) mvals[i] = 32'h000F_FFFF;
    @(negedge clk_i);
    rbr_chk = 1'b1;
    tgl = 1'b1;
    w1_0 = n_w1; w2_0 = n_w2;
    exp_q.push_back(32'h003F_FFFC);
    start_op(3'b101);
    wait_valid(lat);
    chk("rbr_w1", 32'(n_w1 - w1_0), 32'd4);
    chk("rbr_w2", 32'(n_w2 - w2_0), 32'd4);
    take_result("rbr");
    tgl = 1'b0;

    w2_0 = n_w2; sh_0 = n_sh;
    start_op(3'b101);
    n = 0;
    while (!(buf_write_en_2_o && (n_sh - sh_0) == 1) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    abort_i = 1'b1;
    sh_0 = n_sh;
    v0 = n_vld;
    @(negedge clk_i);
    abort_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("abt_idle", 32'(busy_o), 32'd0);
    chk("abt_flush_sh", 32'(n_sh - sh_0), 32'd3);
    chk("abt_w2", 32'(n_w2 - w2_0), 32'd1);
    chk("abt_dpcnt", 32'(dp_cnt), 32'd0);
    chk("abt_novalid", 32'(n_vld - v0), 32'd0);
    rbr_chk = 1'b0;
    for (int i = 0; i < 4; i++) mvals[i] = 32'd1;
    exp_q.push_back(32'd4);
    start_op(3'b100);
    wait_valid(lat);
    take_result("realign");

    w1_0 = n_w1; w2_0 = n_w2; rd_0 = n_rd; sh_0 = n_sh;
    start_op(3'b000);
    chk("merr_pulse", 32'(mode_err_o), 32'd1);
    chk("merr_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("merr_drop", 32'(mode_err_o), 32'd0);
    chk("merr_busy2", 32'(busy_o), 32'd0);
    chk("merr_strobes",
        32'((n_w1 - w1_0) + (n_w2 - w2_0) + (n_rd - rd_0) + (n_sh - sh_0)),
        32'd0);

    start_op(3'b100);
    n = 0;
    while (!buf_read_en_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("rd_reached", 32'(buf_read_en_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_outs", 32'(outs()), 32'd0);
    chk("arst_dpcnt", 32'(dp_cnt), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mvals[0] = 32'd5; mvals[1] = 32'd7;
    mvals[2] = 32'd1; mvals[3] = 32'd2;
    sh_0 = n_sh;
    exp_q.push_back(32'd15);
    start_op(3'b100);
    wait_valid(lat);
    chk("post_latency", 32'(lat), 32'd12);
    chk("post_sh", 32'(n_sh - sh_0), 32'd4);
    take_result("post");

    @(negedge clk_i);
    chk("protocol", 32'(n_bad), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
